// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller for an external MEM_LENGHT-word memory.
// Generates the write/read strobes and addresses, the status flags and a sticky error.
module fifo_ctrl #(
  parameter int MEM_LENGHT = 3,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] almost_full_thr,
  input  logic [ADDR_WIDTH-1:0] almost_empty_thr,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  data_valid,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_LENGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH     = ADDR_WIDTH'(MEM_LENGHT);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  data_valid_q, data_valid_d;
  logic                  error_q, error_d;
  logic                  accept_push, accept_pop;

  assign full         = (count_q == DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= almost_full_thr);
  assign almost_empty = (count_q <= almost_empty_thr);

  // Strobes are gated by reset_L so the memory sees no write/read while reset is held.
  assign accept_pop  = reset_L && pop && !empty;
  assign accept_push = reset_L && push && (!full || accept_pop);

  assign write_enable = accept_push;
  assign read_enable  = accept_pop;
  assign write_addr   = wr_ptr_q;
  assign read_addr    = rd_ptr_q;
  assign count        = count_q;
  assign data_valid   = data_valid_q;
  assign error        = error_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_valid_d = accept_pop;
    error_d      = error_q | (push & !accept_push) | (pop & !accept_pop);

    if (accept_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (accept_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({accept_push, accept_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_valid_q <= data_valid_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios with literal expectations, then
// randomized push/pop/threshold/reset traffic against a queue-based model.
module tb_fifo_ctrl;
  localparam int MEM = 3;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          push, pop;
  logic [AW-1:0] almost_full_thr, almost_empty_thr;
  logic          write_enable, read_enable;
  logic [AW-1:0] write_addr, read_addr, count;
  logic          full, empty, almost_full, almost_empty, data_valid, error;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the queue holds the memory slot of each stored word, oldest first.
  int q[$];
  int m_wptr, m_rptr;
  bit m_dv, m_err;

  fifo_ctrl #(.MEM_LENGHT(MEM), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop),
    .almost_full_thr(almost_full_thr), .almost_empty_thr(almost_empty_thr),
    .write_enable(write_enable), .read_enable(read_enable),
    .write_addr(write_addr), .read_addr(read_addr), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .data_valid(data_valid), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_pop_ok();
    return reset_L && pop && (q.size() != 0);
  endfunction

  function automatic bit m_push_ok();
    return reset_L && push && ((q.size() != MEM) || m_pop_ok());
  endfunction

  task automatic model_reset();
    q.delete();
    m_wptr = 0;
    m_rptr = 0;
    m_dv   = 0;
    m_err  = 0;
  endtask

  task automatic check_all();
    chk("write_enable", write_enable, m_push_ok());
    chk("read_enable", read_enable, m_pop_ok());
    chk("write_addr", write_addr, m_wptr);
    chk("read_addr", read_addr, m_rptr);
    chk("count", count, q.size());
    chk("full", full, q.size() == MEM);
    chk("empty", empty, q.size() == 0);
    chk("almost_full", almost_full, q.size() >= int'(almost_full_thr));
    chk("almost_empty", almost_empty, q.size() <= int'(almost_empty_thr));
    chk("data_valid", data_valid, m_dv);
    chk("error", error, m_err);
    if (q.size() != 0) chk("read_addr_oldest", read_addr, q[0]);
  endtask

  task automatic model_edge();
    bit pu_ok, po_ok;
    if (!reset_L) return;
    pu_ok = m_push_ok();
    po_ok = m_pop_ok();
    if (po_ok) begin
      void'(q.pop_front());
      m_rptr = (m_rptr + 1) % MEM;
    end
    if (pu_ok) begin
      q.push_back(m_wptr);
      m_wptr = (m_wptr + 1) % MEM;
    end
    m_dv  = po_ok;
    m_err = m_err || (push && !pu_ok) || (pop && !po_ok);
  endtask

  // One clock: inputs applied just after the rising edge, checked at the falling edge.
  task automatic step(input bit pu, input bit po);
    push = pu;
    pop  = po;
    @(negedge clk);
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset_L = 1'b1;
  endtask

  initial begin
    int bias_push, bias_pop;
    reset_L = 1'b0;
    push = 1'b1;
    pop  = 1'b1;
    almost_full_thr  = 4'd2;
    almost_empty_thr = 4'd1;
    model_reset();

    #3;
    chk("rst_write_enable", write_enable, 0);
    chk("rst_read_enable", read_enable, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_error", error, 0);
    @(posedge clk);
    #1;
    chk("rst_held_write_addr", write_addr, 0);
    reset_L = 1'b1;
    chk("rel_write_addr", write_addr, 0);

    // Three pushes to full with thresholds 2/1
    step(1, 0);
    chk("p1_write_addr", write_addr, 1);
    chk("p1_almost_empty", almost_empty, 1);
    chk("p1_almost_full", almost_full, 0);
    step(1, 0);
    chk("p2_write_addr", write_addr, 2);
    chk("p2_almost_empty", almost_empty, 0);
    chk("p2_almost_full", almost_full, 1);
    step(1, 0);
    chk("p3_write_addr", write_addr, 0);
    chk("p3_count", count, 3);
    chk("p3_full", full, 1);
    chk("p3_empty", empty, 0);
    chk("p3_error", error, 0);
    chk("p3_almost_empty", almost_empty, 0);
    chk("p3_almost_full", almost_full, 1);

    // Push while full is rejected and error sticks
    push = 1'b1;
    pop  = 1'b0;
    #1;
    chk("ovf_write_enable", write_enable, 0);
    step(1, 0);
    chk("ovf_count", count, 3);
    chk("ovf_error", error, 1);

    // Push and pop together while full
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("pp_write_enable", write_enable, 1);
    chk("pp_read_enable", read_enable, 1);
    step(1, 1);
    chk("pp_count", count, 3);
    chk("pp_write_addr", write_addr, 1);
    chk("pp_read_addr", read_addr, 1);
    chk("pp_error_held", error, 1);

    step(0, 1);
    chk("drain1_data_valid", data_valid, 1);
    step(0, 1);
    step(0, 1);
    chk("drain_read_addr", read_addr, 1);
    chk("drain_empty", empty, 1);

    async_reset();
    chk("rst2_error", error, 0);

    // Pop from empty
    push = 1'b0;
    pop  = 1'b1;
    #1;
    chk("udf_read_enable", read_enable, 0);
    step(0, 1);
    chk("udf_data_valid", data_valid, 0);
    chk("udf_error", error, 1);
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("pe_read_enable", read_enable, 0);
    chk("pe_write_enable", write_enable, 1);
    step(1, 1);
    chk("pe_count", count, 1);
    step(1, 0);
    chk("pre_rst_count", count, 2);

    // Asynchronous reset at count 2
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_write_addr", write_addr, 0);
    chk("arst_read_addr", read_addr, 0);
    chk("arst_error", error, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    push = 1'b1;
    pop  = 1'b0;
    #1;
    chk("post_rst_write_enable", write_enable, 1);
    chk("post_rst_write_addr", write_addr, 0);
    step(1, 0);

    // Randomized traffic
    bias_push = 50;
    bias_pop  = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        bias_push = $urandom_range(10, 90);
        bias_pop  = $urandom_range(10, 90);
        almost_full_thr  = AW'($urandom_range(0, 15));
        almost_empty_thr = AW'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 79) == 0) begin
        push = $urandom_range(0, 1) != 0;
        pop  = $urandom_range(0, 1) != 0;
        async_reset();
      end else begin
        step($urandom_range(0, 99) < bias_push, $urandom_range(0, 99) < bias_pop);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter MEM_LENGHT, default 3, number of memory words; legal range 2..15.
REQ-002 Parameter ADDR_WIDTH, default 4, width of address and count ports; fixed to match the memory address ports.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_L  in  1  asynchronous, active-low reset.
REQ-005 push  in  1  request to write one word this cycle.
REQ-006 pop  in  1  request to read one word this cycle.
REQ-007 almost_full_thr  in  ADDR_WIDTH  almost-full threshold, in words.
REQ-008 almost_empty_thr  in  ADDR_WIDTH  almost-empty threshold, in words.
REQ-009 write_enable  out  1  memory write strobe, asserted for an accepted push.
REQ-010 read_enable  out  1  memory read strobe, asserted for an accepted pop.
REQ-011 write_addr  out  ADDR_WIDTH  memory write pointer.
REQ-012 read_addr  out  ADDR_WIDTH  memory read pointer.
REQ-013 count  out  ADDR_WIDTH  current occupancy, 0..MEM_LENGHT.
REQ-014 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-015 data_valid  out  1  high the cycle memory Fifo_Data_out holds the popped word.
REQ-016 error  out  1  sticky flag for a rejected push or pop.

Function
REQ-017 The block SHALL accept a push when push=1 and (full=0 or an accepted pop occurs in the same cycle).
REQ-018 The block SHALL accept a pop when pop=1 and empty=0; a pop while empty SHALL be rejected even if a push occurs in the same cycle.
REQ-019 write_enable and read_enable SHALL be combinational from push, pop and the registered state, so the memory samples them on the same edge.
REQ-020 write_addr and read_addr SHALL be registered and SHALL drive the current pointer values directly.
REQ-021 On each accepted push, write_addr SHALL increment; on each accepted pop, read_addr SHALL increment; both SHALL wrap from MEM_LENGHT-1 to 0.
REQ-022 count SHALL update as follows: +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-023 full SHALL equal (count==MEM_LENGHT) and empty SHALL equal (count==0), decoded from the registered count with no extra cycle of lag.
REQ-024 almost_full SHALL equal (count>=almost_full_thr) and almost_empty SHALL equal (count<=almost_empty_thr), using unsigned comparison.
REQ-025 data_valid SHALL be a register loaded with read_enable, giving 1-cycle latency to match the memory's registered read.
REQ-026 A rejected push (push=1 while full with no accepted pop) SHALL leave the pointers and count unchanged and SHALL set error.
REQ-027 A rejected pop (pop=1 while empty) SHALL leave the pointers and count unchanged and SHALL set error.
REQ-028 error SHALL hold until reset.

Reset
REQ-029 While reset_L=0, asynchronously and independent of clk, the block SHALL force write_addr=0, read_addr=0, count=0, data_valid=0 and error=0.
REQ-030 While in reset, flags SHALL follow from the reset state: empty=1, full=0, and almost flags per thresholds; write_enable and read_enable SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all occupancy; the first push after release SHALL write address 0.
REQ-032 Release of reset SHALL take effect on the first rising clk edge with reset_L=1; no state SHALL change before that edge.

Verification
REQ-033 Reset, then 3 pushes with MEM_LENGHT=3 -> write_addr 0,1,2,0; count=3; full=1; empty=0; error=0.
REQ-034 From full, one extra push -> write_enable=0, count stays 3, error=1 and remains 1 afterwards.
REQ-035 From full, push+pop in the same cycle -> write_enable=1, read_enable=1, count=3, both pointers advance by 1 with wrap.
REQ-036 From empty, pop -> read_enable=0, data_valid=0 next cycle, error=1; push+pop from empty -> only the push is accepted and count=1.
REQ-037 Thresholds almost_full_thr=2, almost_empty_thr=1, then push 1,2,3 words -> almost_empty 1,0,0 and almost_full 0,1,1.
REQ-038 Assert reset_L=0 between clock edges at count=2 -> count=0, empty=1, pointers=0 and error=0 immediately, without waiting for a clock edge.
